tc_multi: RTL and testbench
===========================

# tc_multi

Parametrised multi-channel timer/counter peripheral, the successor to the single-channel two-mode timer in the processor's device space. It presents `CHANNELS` independent down-counters behind one bridge device slot, each with its own preset, control and sticky interrupt status. All interrupts are OR-reduced onto one `IRQ` line feeding one `PrInt` bit. Registers are read combinationally and written synchronously through the bridge's `DevAddr`/`DevWD`/`DevWrite` path.

## Interface
- `CHANNELS`, 2, number of timer channels, legal range 1..8.
- `WIDTH`, 32, counter and preset width, legal range 8..32. Register bits above `WIDTH` read 0 and are ignored on write.
- `clk` input 1: the single clock.
- `reset` input 1: reset, synchronous and active-high.
- `Addr` input [31:2]: word address. `Addr[3:2]` selects the register, `Addr[6:4]` selects the channel, and higher bits are ignored.
- `WE` input 1: write enable for the addressed register.
- `Din` input 32: write data.
- `Dout` output 32: read data, combinational from `Addr`.
- `IRQ` output 1: OR over channels of (`STATUS.FLAG & CTRL.IM`).

## Operation
- Per-channel registers, selected by `Addr[3:2]`:
  - 0 `CTRL` (R/W): [0] EN, [2:1] MODE, [3] IM.
  - 1 `PRESET` (R/W).
  - 2 `COUNT` (read-only; writes ignored).
  - 3 `STATUS`: [0] FLAG. Reads return the flag. Writing 1 to bit 0 clears it; writing 0 has no effect.
- Accesses to a channel index ≥ `CHANNELS` read 0, and writes to them are ignored.
- MODE values:
  - 00: one-shot.
  - 01: auto-reload.
  - 10 and 11: reserved, behave as 00.
- Per-channel FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT ← PRESET, go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT held. Else if COUNT > 1, COUNT ← COUNT−1. Else COUNT ← 0 and go to INT.
  - INT: FLAG ← 1. In one-shot mode, EN ← 0 and go to IDLE. In auto-reload mode, go to LOAD.
- PRESET values 0 and 1 behave identically, giving the minimum terminal count.
- A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
- FLAG is sticky until cleared by a `STATUS` W1C write or by reset. IM only gates `IRQ`; FLAG sets regardless of IM.
- Channels are fully independent; a write to one channel's registers never affects another channel.

## Timing
- Reset: every `CTRL`, `PRESET`, `COUNT` and `FLAG` is 0, every FSM is in IDLE, and `IRQ` is 0 in the cycle after the reset edge.
  - `Dout` is combinational from `Addr` and therefore reads 0 for all registers after reset.
  - Reset asserted mid-count aborts the channel immediately, with no FLAG set.
- Writes take effect at the clock edge where `WE`=1. Reads reflect register state after the last edge, with no wait states.
- Latency: let edge t be the edge that writes EN=1 with PRESET=N (N≥1).
  - At edge t+1 the FSM enters LOAD.
  - At edge t+2, COUNT = N and the FSM enters CNT.
  - At edge t+N+2 the FSM enters INT.
  - At edge t+N+3, FLAG = 1, so `IRQ` rises N+3 edges after the enabling write.
- Auto-reload period: N+2 cycles between successive INT entries, and FLAG stays high (sticky) across periods.
- Simultaneous events:
  - FLAG set in INT and a W1C in the same cycle: set wins, FLAG=1.
  - A `CTRL` write in the same cycle as INT's EN←0: the `CTRL` write wins.
  - EN written 0 in the same cycle the FSM is in LOAD: LOAD completes, then CNT sees EN=0 and goes to IDLE.

## Configuration
- `TC_AUTORELOAD_EN`:
  - Defined: MODE 01 auto-reloads as described above.
  - Undefined: MODE 01 behaves as one-shot, the auto-reload LOAD path is not built, and `CTRL.MODE` still reads back the written value.

## Test plan
- Reset behaviour, then a single one-shot: reset for 2 cycles, then read all registers of all channels → all 0 and `IRQ`=0. Then channel 0 with PRESET=5, write CTRL=0x9 (EN, IM) → `IRQ` rises exactly 8 edges after the CTRL write, COUNT=0, and CTRL reads 0x8.
- Auto-reload (with `TC_AUTORELOAD_EN` defined): channel 1 with PRESET=3, CTRL=0xB. Clear FLAG each time it sets → FLAG re-sets every 5 cycles. With the macro undefined, the same stimulus produces a single FLAG, then EN=0.
- Masking and W1C: IM=0 with PRESET=2 → FLAG reads 1 and `IRQ` stays 0. Then write CTRL.IM=1 → `IRQ`=1. Write STATUS=1 → `IRQ`=0 the next cycle. Then W1C landing on the same cycle as an INT → FLAG remains 1.
- Pause and preset change: with PRESET=10 and COUNT=6, write EN=0 → COUNT holds at 6. Write PRESET=2 and EN=1 → COUNT reloads to 2 via LOAD and expires 2 cycles later.
- Channel isolation and out-of-range access, with `CHANNELS`=2: run both channels with PRESETs 4 and 7 → each FLAG sets at its own cycle. Read and write channel index 5 → reads 0, and no channel's state changes.
- Reset mid-operation: assert reset while channel 0 is in CNT with COUNT=3 → next cycle all registers are 0, no FLAG is set, and `IRQ`=0.

Source files
------------

// File: rtl/tc_multi.sv
// tc_multi: CHANNELS independent down-counting timers behind one register slot.
// Define TC_AUTORELOAD_EN to build the MODE=01 auto-reload path; otherwise MODE=01 acts as one-shot.
module tc_multi #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t              r_state     [CHANNELS];
    state_t              w_state_nxt [CHANNELS];
    logic [WIDTH-1:0]    r_preset    [CHANNELS];
    logic [WIDTH-1:0]    r_count     [CHANNELS];
    logic [WIDTH-1:0]    w_count_nxt [CHANNELS];
    logic [1:0]          r_mode      [CHANNELS];
    logic [CHANNELS-1:0] r_en;
    logic [CHANNELS-1:0] r_im;
    logic [CHANNELS-1:0] r_flag;
    logic [CHANNELS-1:0] w_en_nxt;
    logic [CHANNELS-1:0] w_flag_nxt;
    logic [CHANNELS-1:0] w_reload;
    logic [CHANNELS-1:0] w_wr_ctrl;
    logic [CHANNELS-1:0] w_wr_preset;
    logic [CHANNELS-1:0] w_wr_status;
    logic [2:0]          w_ch;
    logic [1:0]          w_sel;
    logic                w_unused;

    assign w_sel    = Addr[3:2];
    assign w_ch     = Addr[6:4];
    assign w_unused = ^{Addr[31:7], Din};

    // Channel indices at or above CHANNELS never match, so those writes are dropped.
    always_comb begin
        w_wr_ctrl   = '0;
        w_wr_preset = '0;
        w_wr_status = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (WE && (w_ch == 3'(c))) begin
                w_wr_ctrl[c]   = (w_sel == 2'd0);
                w_wr_preset[c] = (w_sel == 2'd1);
                w_wr_status[c] = (w_sel == 2'd3);
            end
        end
    end

    always_comb begin
        w_reload = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
`ifdef TC_AUTORELOAD_EN
            w_reload[c] = (r_mode[c] == 2'b01);
`else
            w_reload[c] = 1'b0;
`endif
        end
    end

    always_comb begin
        w_en_nxt   = r_en;
        w_flag_nxt = r_flag;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_state_nxt[c] = r_state[c];
            w_count_nxt[c] = r_count[c];
            if (w_wr_status[c] && Din[0]) begin
                w_flag_nxt[c] = 1'b0;
            end
            case (r_state[c])
                S_IDLE: begin
                    if (r_en[c]) begin
                        w_state_nxt[c] = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_count_nxt[c] = r_preset[c];
                    w_state_nxt[c] = S_CNT;
                end
                S_CNT: begin
                    if (!r_en[c]) begin
                        w_state_nxt[c] = S_IDLE;
                    end else if (r_count[c] > WIDTH'(1)) begin
                        w_count_nxt[c] = r_count[c] - WIDTH'(1);
                    end else begin
                        w_count_nxt[c] = '0;
                        w_state_nxt[c] = S_INT;
                    end
                end
                default: begin
                    // Terminal-count set overrides a simultaneous W1C.
                    w_flag_nxt[c] = 1'b1;
                    if (w_reload[c]) begin
                        w_state_nxt[c] = S_LOAD;
                    end else begin
                        w_en_nxt[c]    = 1'b0;
                        w_state_nxt[c] = S_IDLE;
                    end
                end
            endcase
            // A CTRL write lands after the one-shot EN clear so software always wins.
            if (w_wr_ctrl[c]) begin
                w_en_nxt[c] = Din[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en   <= '0;
            r_im   <= '0;
            r_flag <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_state[c]  <= S_IDLE;
                r_preset[c] <= '0;
                r_count[c]  <= '0;
                r_mode[c]   <= '0;
            end
        end else begin
            r_en   <= w_en_nxt;
            r_flag <= w_flag_nxt;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_count[c] <= w_count_nxt[c];
                if (w_wr_ctrl[c]) begin
                    r_mode[c] <= Din[2:1];
                    r_im[c]   <= Din[3];
                end
                if (w_wr_preset[c]) begin
                    r_preset[c] <= Din[WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        Dout = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (w_ch == 3'(c)) begin
                case (w_sel)
                    2'd0:    Dout[3:0]       = {r_im[c], r_mode[c], r_en[c]};
                    2'd1:    Dout[WIDTH-1:0] = r_preset[c];
                    2'd2:    Dout[WIDTH-1:0] = r_count[c];
                    default: Dout[0]         = r_flag[c];
                endcase
            end
        end
    end

    assign IRQ = |(r_flag & r_im);

endmodule

// File: tb/tb_tc_multi.sv
// Scoreboard bench for tc_multi: stimulus queues expected reads, a monitor compares on each read strobe.
module tb_tc_multi;

`ifdef TC_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        rd_valid;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_irq;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    tc_multi #(.CHANNELS(2), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge rd_valid) begin : monitor
        exp_t        e;
        logic [31:0] act;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: no expectation queued, Dout=0x%08h", Dout);
        end else begin
            e   = sb.pop_front();
            act = e.is_irq ? {31'd0, IRQ} : Dout;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    function automatic logic [31:2] ra(input int ch, input int r);
        return {25'd0, ch[2:0], r[1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [31:2] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic chk(input int ch, input int r, input logic [31:0] e, input string nm);
        exp_t x;
        Addr     = ra(ch, r);
        x.is_irq = 1'b0;
        x.exp    = e;
        x.name   = $sformatf("%s_ch%0d_r%0d", nm, ch, r);
        sb.push_back(x);
        #1 rd_valid = 1'b1;
        #1 rd_valid = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string nm);
        exp_t x;
        x.is_irq = 1'b1;
        x.exp    = {31'd0, e};
        x.name   = nm;
        sb.push_back(x);
        #1 rd_valid = 1'b1;
        #1 rd_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 0; r < 4; r++) chk(ch, r, 32'h0, nm);
            tick();
        end
        chk_irq(1'b0, {nm, "_irq"});
    endtask

    initial begin
        reset    = 1'b1;
        WE       = 1'b0;
        Addr     = '0;
        Din      = '0;
        rd_valid = 1'b0;

        // Reset, then one-shot on channel 0 with PRESET=5
        ticks(2);
        reset = 1'b0;
        chk_all_zero("reset");
        wr(ra(0, 1), 32'd5);
        wr(ra(0, 0), 32'h9);
        ticks(2);
        chk(0, 2, 32'd5, "os_load");
        ticks(5);
        chk_irq(1'b0, "os_irq_edge7");
        chk(0, 2, 32'd0, "os_count_int");
        tick();
        chk_irq(1'b1, "os_irq_edge8");
        chk(0, 2, 32'd0, "os_count_done");
        chk(0, 0, 32'h8, "os_ctrl_en_cleared");
        chk(0, 3, 32'h1, "os_flag");
        wr(ra(0, 3), 32'h1);
        chk_irq(1'b0, "os_irq_cleared");

        // Auto-reload on channel 1 with PRESET=3
        wr(ra(1, 1), 32'd3);
        wr(ra(1, 0), 32'hB);
        ticks(5);
        chk(1, 3, 32'h0, "ar_flag_t5");
        tick();
        chk(1, 3, 32'h1, "ar_flag_t6");
        chk(1, 0, AR ? 32'hB : 32'hA, "ar_ctrl_t6");
        wr(ra(1, 3), 32'h1);
        chk(1, 3, 32'h0, "ar_w1c_t7");
        ticks(3);
        chk(1, 3, 32'h0, "ar_flag_t10");
        tick();
        chk(1, 3, AR ? 32'h1 : 32'h0, "ar_flag_t11");
        wr(ra(1, 3), 32'h1);
        chk(1, 3, 32'h0, "ar_w1c_t12");
        ticks(3);
        chk(1, 3, 32'h0, "ar_flag_t15");
        tick();
        chk(1, 3, AR ? 32'h1 : 32'h0, "ar_flag_t16");
        wr(ra(1, 0), 32'h0);
        ticks(2);
        wr(ra(1, 3), 32'h1);
        chk(1, 3, 32'h0, "ar_stopped_flag");
        chk(1, 0, 32'h0, "ar_stopped_ctrl");

        // Masking and W1C on channel 0 with PRESET=2
        wr(ra(0, 1), 32'd2);
        wr(ra(0, 0), 32'h1);
        ticks(5);
        chk(0, 3, 32'h1, "mask_flag");
        chk_irq(1'b0, "mask_irq_low");
        wr(ra(0, 0), 32'h8);
        chk_irq(1'b1, "mask_irq_unmasked");
        wr(ra(0, 3), 32'h1);
        chk_irq(1'b0, "mask_irq_w1c");
        chk(0, 3, 32'h0, "mask_flag_w1c");
        wr(ra(0, 0), 32'h1);
        ticks(4);
        wr(ra(0, 3), 32'h1);
        chk(0, 3, 32'h1, "w1c_vs_int_flag");
        chk(0, 0, 32'h0, "w1c_vs_int_ctrl");
        wr(ra(0, 3), 32'h1);
        chk(0, 3, 32'h0, "w1c_after");

        // Pause at COUNT=6, then reload with a new PRESET
        wr(ra(0, 1), 32'd10);
        wr(ra(0, 0), 32'h1);
        ticks(5);
        wr(ra(0, 0), 32'h0);
        chk(0, 2, 32'd6, "pause_count");
        ticks(3);
        chk(0, 2, 32'd6, "pause_hold");
        chk(0, 3, 32'h0, "pause_flag");
        wr(ra(0, 1), 32'd2);
        chk(0, 2, 32'd6, "preset_no_disturb");
        wr(ra(0, 0), 32'h1);
        tick();
        chk(0, 2, 32'd6, "resume_load");
        tick();
        chk(0, 2, 32'd2, "resume_count2");
        tick();
        chk(0, 2, 32'd1, "resume_count1");
        tick();
        chk(0, 2, 32'd0, "resume_count0");
        chk(0, 3, 32'h0, "resume_flag_pre");
        tick();
        chk(0, 3, 32'h1, "resume_flag");
        chk(0, 0, 32'h0, "resume_ctrl");
        wr(ra(0, 3), 32'h1);

        // Channel isolation: PRESET 4 on ch0, 7 on ch1, enabled one edge apart
        wr(ra(0, 1), 32'd4);
        wr(ra(1, 1), 32'd7);
        wr(ra(0, 0), 32'h1);
        wr(ra(1, 0), 32'h1);
        ticks(5);
        chk(0, 3, 32'h0, "iso_ch0_t6");
        tick();
        chk(0, 3, 32'h1, "iso_ch0_t7");
        chk(1, 3, 32'h0, "iso_ch1_t7");
        ticks(3);
        chk(1, 3, 32'h0, "iso_ch1_t10");
        tick();
        chk(1, 3, 32'h1, "iso_ch1_t11");
        chk_irq(1'b0, "iso_irq_masked");

        // Out-of-range channel 5
        wr(ra(5, 0), 32'hF);
        wr(ra(5, 1), 32'h55);
        wr(ra(5, 3), 32'h1);
        for (int r = 0; r < 4; r++) chk(5, r, 32'h0, "oor_read");
        tick();
        chk(0, 0, 32'h0, "oor_ctrl");
        chk(1, 0, 32'h0, "oor_ctrl");
        chk(0, 1, 32'd4, "oor_preset");
        chk(1, 1, 32'd7, "oor_preset");
        chk(0, 3, 32'h1, "oor_flag");
        chk(1, 3, 32'h1, "oor_flag");
        ticks(12);
        chk(0, 2, 32'h0, "oor_count_idle");
        chk(1, 2, 32'h0, "oor_count_idle");
        chk(0, 0, 32'h0, "oor_ctrl_late");
        chk(1, 0, 32'h0, "oor_ctrl_late");

        // Reset mid-count
        wr(ra(0, 3), 32'h1);
        wr(ra(1, 3), 32'h1);
        wr(ra(0, 1), 32'd5);
        wr(ra(0, 0), 32'h9);
        ticks(4);
        chk(0, 2, 32'd3, "midrst_count");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("midrst");
        ticks(8);
        chk(0, 3, 32'h0, "midrst_flag_late");
        chk(0, 2, 32'h0, "midrst_count_late");
        chk_irq(1'b0, "midrst_irq_late");

        tick();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
